// File: rtl/tile_game_pkg.sv
// Shared types and constants for the reaction-tile game sequencer.
package tile_game_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StOver = 2'd2
  } state_e;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;

  localparam int unsigned TILE_IDX_W = 3;

  // Lives never wrap below zero.
  function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : 4'd0;
  endfunction

endpackage

// File: rtl/tile_game_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first pending index at or after ptr, wrapping at N.
module rr_arbiter
  import tile_game_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]            pending_i,
  input  logic [TILE_IDX_W-1:0]   ptr_i,
  output logic [TILE_IDX_W-1:0]   grant_o,
  output logic                    valid_o
);

  // First pass covers [ptr, N); second pass falls back to the lowest pending index.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!valid_o && pending_i[i] && (i >= int'(ptr_i))) begin
        valid_o = 1'b1;
        grant_o = TILE_IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!valid_o && pending_i[i]) begin
        valid_o = 1'b1;
        grant_o = TILE_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tile_game_ctrl.sv
// Game sequencer for an array of reaction tiles: FSM, tile tick, lives counter and a
// round-robin draw arbiter sharing one plotter among all tiles.
module tile_game_ctrl
  import tile_game_pkg::*;
#(
  parameter int unsigned N_TILES    = 4,
  parameter int unsigned LIVES_INIT = 3,
  parameter int unsigned TICK_DIV   = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start_key,
  input  logic [N_TILES-1:0]      tile_lose_life,
  input  logic [3*N_TILES-1:0]    tile_colour,
  output logic                    tile_enable,
  output logic                    tile_resetn,
  output logic [3:0]              lives,
  output logic                    game_over,
  output logic                    draw_req,
  output logic [TILE_IDX_W-1:0]   draw_tile,
  output logic [2:0]              draw_colour,
  input  logic                    draw_ack
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  state_e                  state_q, state_d;
  logic [3:0]              lives_q, lives_d, lives_left, lose_cnt;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    enable_q, enable_d;
  logic                    start_key_q, start_edge;

  logic [3*N_TILES-1:0]    shadow_q, shadow_d;
  logic [TILE_IDX_W-1:0]   ptr_q, ptr_d;
  logic                    req_q, req_d;
  logic [TILE_IDX_W-1:0]   tile_q, tile_d;
  logic [2:0]              colour_q, colour_d;
  logic [N_TILES-1:0]      pending;
  logic [TILE_IDX_W-1:0]   grant;
  logic                    grant_valid;
  logic [2:0]              grant_colour;

  assign start_edge = start_key & ~start_key_q;

  always_comb begin
    lose_cnt = '0;
    for (int i = 0; i < int'(N_TILES); i++) begin
      lose_cnt = lose_cnt + 4'(tile_lose_life[i]);
    end
  end

  assign lives_left = sat_sub(lives_q, lose_cnt);

  // Counter is zero outside PLAY, so a fresh game always starts the tick phase at 0.
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    cnt_d    = '0;
    enable_d = 1'b0;
    unique case (state_q)
      StIdle, StOver: begin
        if (start_edge) begin
          state_d = StPlay;
          lives_d = 4'(LIVES_INIT);
        end
      end
      StPlay: begin
        lives_d = lives_left;
        if (lives_left == 4'd0) begin
          state_d = StOver;
        end else begin
          cnt_d    = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
          enable_d = (cnt_q == CntLast);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      lives_q     <= '0;
      cnt_q       <= '0;
      enable_q    <= 1'b0;
      start_key_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      enable_q    <= enable_d;
      start_key_q <= start_key;
    end
  end

  assign tile_enable = enable_q;
  assign tile_resetn = (state_q == StPlay);
  assign game_over   = (state_q == StOver);
  assign lives       = lives_q;

  always_comb begin
    for (int i = 0; i < int'(N_TILES); i++) begin
      pending[i] = (tile_colour[3*i +: 3] != shadow_q[3*i +: 3]);
    end
  end

  rr_arbiter #(
    .N (N_TILES)
  ) u_rr_arbiter (
    .pending_i (pending),
    .ptr_i     (ptr_q),
    .grant_o   (grant),
    .valid_o   (grant_valid)
  );

  always_comb begin
    grant_colour = BLACK;
    for (int i = 0; i < int'(N_TILES); i++) begin
      if (grant == TILE_IDX_W'(i)) grant_colour = tile_colour[3*i +: 3];
    end
  end

  // Request fields freeze while outstanding; a tile that changed again stays pending.
  always_comb begin
    req_d    = req_q;
    tile_d   = tile_q;
    colour_d = colour_q;
    shadow_d = shadow_q;
    ptr_d    = ptr_q;
    if (req_q) begin
      if (draw_ack) begin
        req_d = 1'b0;
        for (int i = 0; i < int'(N_TILES); i++) begin
          if (tile_q == TILE_IDX_W'(i)) shadow_d[3*i +: 3] = colour_q;
        end
        ptr_d = (tile_q == TILE_IDX_W'(N_TILES - 1)) ? '0 : tile_q + TILE_IDX_W'(1);
      end
    end else if (grant_valid) begin
      req_d    = 1'b1;
      tile_d   = grant;
      colour_d = grant_colour;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_q    <= 1'b0;
      tile_q   <= '0;
      colour_q <= BLACK;
      shadow_q <= '0;
      ptr_q    <= '0;
    end else begin
      req_q    <= req_d;
      tile_q   <= tile_d;
      colour_q <= colour_d;
      shadow_q <= shadow_d;
      ptr_q    <= ptr_d;
    end
  end

  assign draw_req    = req_q;
  assign draw_tile   = tile_q;
  assign draw_colour = colour_q;

endmodule
